// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM stage: RV32I load/store width encodings and the
// data-cache access FSM state, plus store lane/mask helpers.
package rv32i_types;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;
endpackage

package memctrl_pkg;
    import rv32i_types::*;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Undefined width encodings fall through to word handling.
    function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (load_funct3_t'(f3))
            LB, LBU: return 1'b1;
            LH, LHU: return ~a[0];
            default: return a == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        case (store_funct3_t'(f3))
            SB:      return 4'b0001 << a;
            SH:      return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (store_funct3_t'(f3))
            SB:      return {4{d[7:0]}};
            SH:      return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction
endpackage

// File: rtl/mem_stage_ctrl_load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/halfword from
// the cache word and sign- or zero-extends it according to funct3.
module load_formatter
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] mdr
);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        unique case (offset)
            2'd0: sel_b = rdata[7:0];
            2'd1: sel_b = rdata[15:8];
            2'd2: sel_b = rdata[23:16];
            2'd3: sel_b = rdata[31:24];
        endcase
        sel_h = offset[1] ? rdata[31:16] : rdata[15:0];

        mdr = rdata;
        case (load_funct3_t'(funct3))
            LB:      mdr = {{24{sel_b[7]}}, sel_b};
            LBU:     mdr = {24'h0, sel_b};
            LH:      mdr = {{16{sel_h[15]}}, sel_h};
            LHU:     mdr = {16'h0, sel_h};
            default: mdr = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs dcache read/write ops with a level request held
// until a one-cycle response, stalls the pipeline meanwhile, loads MEM/WB.
module mem_stage_ctrl
    import memctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_dcache_read,
    input  logic            ex_dcache_write,
    input  logic            ex_load_regfile,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_store_data,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_address,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_byte_en,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_load_regfile,
    output logic [XLEN-1:0] wb_mdr,
    output logic            misalign_err,
    output logic            ctrl_err,
    output logic            mem_timeout
);
    mem_state_t  state;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        lrf_q;
    logic [31:0] wd_cnt;
    logic [31:0] fmt_mdr;

    logic is_mem, both, aligned, accept;

    assign is_mem  = ex_dcache_read ^ ex_dcache_write;
    assign both    = ex_dcache_read & ex_dcache_write;
    assign aligned = access_aligned(ex_funct3, ex_addr[1:0]);
    assign accept  = ex_valid && is_mem && aligned;

    // Stall drops in the response cycle so EX/MEM advances on the same edge
    // that loads MEM/WB; held low during reset so all outputs read 0.
    assign stall = rst && ((state == IDLE) ? accept : !dmem_resp);

    load_formatter u_fmt (
        .rdata  (dmem_rdata),
        .funct3 (funct3_q),
        .offset (off_q),
        .mdr    (fmt_mdr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            dmem_read       <= 1'b0;
            dmem_write      <= 1'b0;
            dmem_address    <= '0;
            dmem_wdata      <= '0;
            dmem_byte_en    <= '0;
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_load_regfile <= 1'b0;
            wb_mdr          <= '0;
            misalign_err    <= 1'b0;
            ctrl_err        <= 1'b0;
            mem_timeout     <= 1'b0;
            rd_q            <= '0;
            funct3_q        <= '0;
            off_q           <= '0;
            lrf_q           <= 1'b0;
            wd_cnt          <= '0;
        end else begin
            misalign_err <= 1'b0;
            ctrl_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    wb_valid        <= ex_valid;
                    wb_rd           <= ex_rd;
                    wb_load_regfile <= ex_valid & ex_load_regfile;
                    wb_mdr          <= '0;
                    if (ex_valid && both) begin
                        ctrl_err        <= 1'b1;
                        wb_load_regfile <= 1'b0;
                    end else if (ex_valid && is_mem && !aligned) begin
                        misalign_err    <= 1'b1;
                        wb_load_regfile <= 1'b0;
                    end else if (accept) begin
                        // MEM/WB takes a bubble while the access is outstanding.
                        wb_valid        <= 1'b0;
                        wb_load_regfile <= 1'b0;
                        state           <= ACCESS;
                        dmem_read       <= ex_dcache_read;
                        dmem_write      <= ex_dcache_write;
                        dmem_address    <= {ex_addr[31:2], 2'b00};
                        dmem_byte_en    <= ex_dcache_write ? store_mask(ex_funct3, ex_addr[1:0]) : 4'b0000;
                        dmem_wdata      <= ex_dcache_write ? store_lanes(ex_funct3, ex_store_data) : '0;
                        rd_q            <= ex_rd;
                        funct3_q        <= ex_funct3;
                        off_q           <= ex_addr[1:0];
                        lrf_q           <= ex_load_regfile;
                        wd_cnt          <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state           <= IDLE;
                        dmem_read       <= 1'b0;
                        dmem_write      <= 1'b0;
                        wb_valid        <= 1'b1;
                        wb_rd           <= rd_q;
                        wb_load_regfile <= lrf_q;
                        wb_mdr          <= dmem_read ? fmt_mdr : '0;
                    end else if (TIMEOUT_CYC != 0 && wd_cnt != TIMEOUT_CYC) begin
                        wd_cnt <= wd_cnt + 32'd1;
                        if (wd_cnt + 32'd1 == TIMEOUT_CYC)
                            mem_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
